hazard_fwd_unit: RTL and testbench

Forwarding and hazard control unit for the 64-bit RISC-V pipeline: it produces the operand forwarding selects consumed by the EX stage (SelFwA, SelFwB, SelFwWD) plus the load-use stall. It sits between ID and EX. It keeps a shadow scoreboard of destination registers for the three older in-flight instructions. When an instruction issues from ID into EX, the unit registers the selects that instruction will need during its EX cycle.

---
 rtl/hazard_fwd_unit.sv | 123 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Forwarding and load-use hazard control for the 64-bit RISC-V pipeline.
// Keeps a shadow scoreboard of the three older in-flight instructions
// (s1 = EX, s2 = MEM, s3 = WB) and registers the EX operand selects for
// the instruction issuing from ID. The stall output is the only
// combinational output.
module hazard_fwd_unit #(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs1,
   input  logic [REG_BITS-1:0] id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   input  logic                id_is_store,
   input  logic                flush,
   output logic [1:0]          SelFwA,
   output logic [1:0]          SelFwB,
   output logic                SelFwWD,
   output logic                stall,
   output logic [CNT_BITS-1:0] stall_count
);

   // Slot contents. Only the EX slot needs mem_read: a load further down
   // the pipe already has its data available for forwarding.
   logic                s1_vld_p1, s2_vld_p2, s3_vld_p3;
   logic                s1_rw_p1,  s2_rw_p2,  s3_rw_p3;
   logic                s1_mr_p1;
   logic [REG_BITS-1:0] s1_rd_p1,  s2_rd_p2,  s3_rd_p3;

   logic                use_b;
   logic                a1, a2, a3, b1, b2, b3;
   logic                issue;
   logic [1:0]          sel_a_nxt, sel_b_nxt;
   logic                sel_wd_nxt;

   // Producer match: x0 never matches and an unused source never matches.
   function automatic logic prod_match(input logic                vld,
                                       input logic                rw,
                                       input logic [REG_BITS-1:0] rd,
                                       input logic [REG_BITS-1:0] r,
                                       input logic                used);
      return vld && rw && (rd == r) && (r != '0) && used;
   endfunction

   // Saturating increment for the stall performance counter.
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A store always reads rs2 as its store data.
   assign use_b = id_use_rs2 | id_is_store;

   // Source matches against each scoreboard slot, then the load-use stall
   // and the youngest-wins select priority for the issuing instruction.
   always_comb begin
      a1 = prod_match(s1_vld_p1, s1_rw_p1, s1_rd_p1, id_rs1, id_use_rs1);
      a2 = prod_match(s2_vld_p2, s2_rw_p2, s2_rd_p2, id_rs1, id_use_rs1);
      a3 = prod_match(s3_vld_p3, s3_rw_p3, s3_rd_p3, id_rs1, id_use_rs1);
      b1 = prod_match(s1_vld_p1, s1_rw_p1, s1_rd_p1, id_rs2, use_b);
      b2 = prod_match(s2_vld_p2, s2_rw_p2, s2_rd_p2, id_rs2, use_b);
      b3 = prod_match(s3_vld_p3, s3_rw_p3, s3_rd_p3, id_rs2, use_b);

      stall = id_valid && !flush && s1_mr_p1 && (a1 || b1);
      issue = id_valid && !flush && !stall;

      sel_a_nxt  = 2'd0;
      sel_b_nxt  = 2'd0;
      sel_wd_nxt = 1'b0;
      if (issue) begin
         if (a1)      sel_a_nxt = 2'd1;
         else if (a2) sel_a_nxt = 2'd2;
         else if (a3) sel_a_nxt = 2'd3;

         if (id_is_store) begin
            // Operand B of a store is the immediate; rs2 goes through FwWD.
            sel_wd_nxt = b1 || b2 || b3;
         end else begin
            if (b1)      sel_b_nxt = 2'd1;
            else if (b2) sel_b_nxt = 2'd2;
            else if (b3) sel_b_nxt = 2'd3;
         end
      end
   end

   // ID -> EX boundary: control state (slot valids, selects, counter).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_p1   <= 1'b0;
         s2_vld_p2   <= 1'b0;
         s3_vld_p3   <= 1'b0;
         SelFwA      <= 2'd0;
         SelFwB      <= 2'd0;
         SelFwWD     <= 1'b0;
         stall_count <= '0;
      end else begin
         s1_vld_p1 <= issue;
         s2_vld_p2 <= s1_vld_p1;
         s3_vld_p3 <= s2_vld_p2;
         SelFwA    <= sel_a_nxt;
         SelFwB    <= sel_b_nxt;
         SelFwWD   <= sel_wd_nxt;
         if (stall) stall_count <= sat_inc(stall_count);
      end
   end

   // EX -> MEM -> WB boundaries: slot payload, qualified by the valids above.
   always_ff @(posedge clk) begin
      s1_rd_p1 <= issue ? id_rd : '0;
      s1_rw_p1 <= issue && id_reg_write;
      s1_mr_p1 <= issue && id_mem_read;
      s2_rd_p2 <= s1_rd_p1;
      s2_rw_p2 <= s1_rw_p1;
      s3_rd_p3 <= s2_rd_p2;
      s3_rw_p3 <= s2_rw_p2;
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. The counter is shrunk to 3 bits so
// saturation is reachable in a handful of stalls.
module tb_hazard_fwd_unit;

   localparam int RB = 5;
   localparam int CB = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid;
   logic [RB-1:0] id_rs1, id_rs2, id_rd;
   logic          id_use_rs1, id_use_rs2;
   logic          id_reg_write, id_mem_read, id_is_store, flush;
   logic [1:0]    SelFwA, SelFwB;
   logic          SelFwWD, stall;
   logic [CB-1:0] stall_count;

   int total = 0;
   int bad   = 0;
   int exp_dist [4] = '{1, 2, 3, 0};

   hazard_fwd_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_is_store(id_is_store), .flush(flush),
      .SelFwA(SelFwA), .SelFwB(SelFwB), .SelFwWD(SelFwWD),
      .stall(stall), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one real instruction in ID (both sources used).
   task automatic op(input logic [RB-1:0] rs1, input logic [RB-1:0] rs2,
                     input logic [RB-1:0] rd, input logic rw, input logic mr,
                     input logic st, input logic fl);
      id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      id_reg_write = rw; id_mem_read = mr; id_is_store = st; flush = fl;
      #1;
   endtask

   // Push three non-writing fillers so no producer remains in the scoreboard.
   task automatic clear_sb();
      for (int i = 0; i < 3; i++) begin
         op(1, 2, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      op(0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      chk("rst_selA", SelFwA, 0);
      chk("rst_selB", SelFwB, 0);
      chk("rst_selWD", SelFwWD, 0);
      chk("rst_cnt", stall_count, 0);
      chk("rst_stall", stall, 0);
      rst_n = 1'b1;

      // Independent op.
      op(1, 2, 3, 1, 0, 0, 0);
      chk("indep_stall", stall, 0);
      tick();
      chk("indep_selA", SelFwA, 0);
      chk("indep_selB", SelFwB, 0);
      chk("indep_selWD", SelFwWD, 0);
      chk("indep_cnt", stall_count, 0);

      // Producer distance 0..3 gaps.
      for (int g = 0; g < 4; g++) begin
         clear_sb();
         op(1, 2, 5, 1, 0, 0, 0); tick();
         for (int k = 0; k < g; k++) begin
            op(1, 2, 0, 0, 0, 0, 0); tick();
         end
         op(5, 2, 0, 0, 0, 0, 0); tick();
         chk($sformatf("dist%0d_selA", g), SelFwA, exp_dist[g]);
      end

      // Youngest producer wins.
      clear_sb();
      op(1, 2, 5, 1, 0, 0, 0); tick();
      op(1, 2, 5, 1, 0, 0, 0); tick();
      op(5, 5, 0, 0, 0, 0, 0); tick();
      chk("young_selA", SelFwA, 1);
      chk("young_selB", SelFwB, 1);

      // x0 never forwards.
      clear_sb();
      op(1, 2, 0, 1, 0, 0, 0); tick();
      op(0, 0, 0, 0, 0, 0, 0); tick();
      chk("x0_selA", SelFwA, 0);
      chk("x0_selB", SelFwB, 0);

      // Load-use on rs2.
      clear_sb();
      op(1, 2, 7, 1, 1, 0, 0); tick();
      op(1, 7, 0, 0, 0, 0, 0);
      chk("lu_stall", stall, 1);
      tick();
      chk("lu_bub_selA", SelFwA, 0);
      chk("lu_bub_selB", SelFwB, 0);
      chk("lu_cnt", stall_count, 1);
      chk("lu_stall_fall", stall, 0);
      tick();
      chk("lu_selB", SelFwB, 2);
      chk("lu_cnt_hold", stall_count, 1);

      // Store data forwarding from an ALU producer.
      clear_sb();
      op(1, 2, 9, 1, 0, 0, 0); tick();
      op(1, 9, 0, 0, 0, 1, 0);
      chk("st_stall", stall, 0);
      tick();
      chk("st_selWD", SelFwWD, 1);
      chk("st_selB", SelFwB, 0);
      chk("st_selA", SelFwA, 0);

      // Store data from a load: one stall, then FwWD.
      clear_sb();
      op(1, 2, 9, 1, 1, 0, 0); tick();
      op(1, 9, 0, 0, 0, 1, 0);
      chk("ldst_stall", stall, 1);
      tick();
      chk("ldst_bub_selWD", SelFwWD, 0);
      chk("ldst_stall_fall", stall, 0);
      tick();
      chk("ldst_selWD", SelFwWD, 1);
      chk("ldst_selB", SelFwB, 0);
      chk("ldst_cnt", stall_count, 2);

      // Flush beats stall.
      clear_sb();
      op(1, 2, 7, 1, 1, 0, 0); tick();
      op(1, 7, 0, 0, 0, 0, 1);
      chk("fl_stall", stall, 0);
      tick();
      chk("fl_selA", SelFwA, 0);
      chk("fl_selB", SelFwB, 0);
      chk("fl_cnt", stall_count, 2);
      op(1, 7, 0, 0, 0, 0, 0);
      chk("fl_after_stall", stall, 0);
      tick();
      chk("fl_after_selB", SelFwB, 2);

      // Seven more stalls push the 3-bit counter past 7; it must hold.
      for (int p = 0; p < 7; p++) begin
         op(1, 2, 7, 1, 1, 0, 0); tick();
         op(1, 7, 0, 0, 0, 0, 0); tick();
         tick();
      end
      chk("sat_cnt", stall_count, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
